// File: rtl/axil_sram_slave.sv
// AXI-Lite slave around a word-addressed on-chip memory.
// Handles one transaction at a time. Reads take priority over writes.
// Each response is returned after a fixed, parameterised latency.
// Addresses outside the memory window get SLVERR.

package axil_sram_pkg;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;
endpackage

module axil_sram_slave
    import axil_sram_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned WR_LAT    = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        slv_ar_valid_i,
    input  logic [31:0] slv_ar_addr_i,
    output logic        slv_ar_ready_o,
    output logic        slv_r_valid_o,
    output logic [31:0] slv_r_data_o,
    output axi_resp_t   slv_r_resp_o,
    input  logic        slv_r_ready_i,
    input  logic        slv_aw_valid_i,
    input  logic [31:0] slv_aw_addr_i,
    output logic        slv_aw_ready_o,
    input  logic        slv_w_valid_i,
    input  logic [31:0] slv_w_data_i,
    input  logic [3:0]  slv_w_strb_i,
    output logic        slv_w_ready_o,
    output logic        slv_b_valid_o,
    output axi_resp_t   slv_b_resp_o,
    input  logic        slv_b_ready_i
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    typedef enum logic [5:0] {
        IDLE       = 6'b000001,
        RD_WAIT    = 6'b000010,
        RD_RSP     = 6'b000100,
        WR_COLLECT = 6'b001000,
        WR_WAIT    = 6'b010000,
        WR_RSP     = 6'b100000
    } state_t;

    // With a latency of 1 the wait state is skipped entirely.
    localparam state_t RD_GO = (RD_LAT > 1) ? RD_WAIT : RD_RSP;
    localparam state_t WR_GO = (WR_LAT > 1) ? WR_WAIT : WR_RSP;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [31:0] ar_addr_q, aw_addr_q, w_data_q, r_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_got_q, w_got_q;
    axi_resp_t   r_resp_q, b_resp_q;
    logic [31:0] mem [DEPTH];

    logic        ar_hs, aw_hs, w_hs;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic [32:0] rd_off, wr_off;
    logic        rd_ok, wr_ok, rd_enter, wr_enter, wr_commit;
    logic [IDX_W-1:0] rd_idx, wr_idx;

    // Readies depend only on the state and on ar_valid. ar_valid is what gives reads priority.
    assign slv_ar_ready_o = (state_q == IDLE);
    assign slv_aw_ready_o = (state_q == IDLE) ? ~slv_ar_valid_i : ((state_q == WR_COLLECT) & ~aw_got_q);
    assign slv_w_ready_o  = (state_q == IDLE) ? ~slv_ar_valid_i : ((state_q == WR_COLLECT) & ~w_got_q);
    assign slv_r_valid_o  = (state_q == RD_RSP);
    assign slv_b_valid_o  = (state_q == WR_RSP);
    assign slv_r_data_o   = r_data_q;
    assign slv_r_resp_o   = r_resp_q;
    assign slv_b_resp_o   = b_resp_q;

    assign ar_hs = slv_ar_valid_i & slv_ar_ready_o;
    assign aw_hs = slv_aw_valid_i & slv_aw_ready_o;
    assign w_hs  = slv_w_valid_i & slv_w_ready_o;

    // A beat handshaking this cycle is not yet in its register, so take it straight from the port.
    assign rd_addr = (state_q == IDLE) ? slv_ar_addr_i : ar_addr_q;
    assign wr_addr = aw_got_q ? aw_addr_q : slv_aw_addr_i;
    assign wr_data = w_got_q ? w_data_q : slv_w_data_i;
    assign wr_strb = w_got_q ? w_strb_q : slv_w_strb_i;

    // 33-bit offset: an address below BASE_ADDR wraps to a huge value and fails the range check.
    assign rd_off = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
    assign wr_off = {1'b0, wr_addr} - {1'b0, BASE_ADDR};
    assign rd_ok  = (rd_off < SPAN);
    assign wr_ok  = (wr_off < SPAN);
    assign rd_idx = rd_off[IDX_W+1:2];
    assign wr_idx = wr_off[IDX_W+1:2];

    assign rd_enter  = (state_d == RD_RSP) && (state_q != RD_RSP);
    assign wr_enter  = (state_d == WR_RSP) && (state_q != WR_RSP);
    assign wr_commit = wr_enter && wr_ok && !rst_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ar_hs)                state_d = RD_GO;
                else if (aw_hs && w_hs)   state_d = WR_GO;
                else if (aw_hs || w_hs)   state_d = WR_COLLECT;
            end
            WR_COLLECT: if ((aw_got_q | aw_hs) && (w_got_q | w_hs)) state_d = WR_GO;
            RD_WAIT:    if (cnt_q <= 4'd1) state_d = RD_RSP;
            WR_WAIT:    if (cnt_q <= 4'd1) state_d = WR_RSP;
            RD_RSP:     if (slv_r_ready_i) state_d = IDLE;
            WR_RSP:     if (slv_b_ready_i) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Capture request beats, run the latency counter, register the responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            cnt_q    <= 4'd0;
            r_data_q <= 32'h0;
            r_resp_q <= RESP_OKAY;
            b_resp_q <= RESP_OKAY;
        end else begin
            if (ar_hs) ar_addr_q <= slv_ar_addr_i;
            if (aw_hs) begin
                aw_addr_q <= slv_aw_addr_i;
                aw_got_q  <= 1'b1;
            end
            if (w_hs) begin
                w_data_q <= slv_w_data_i;
                w_strb_q <= slv_w_strb_i;
                w_got_q  <= 1'b1;
            end
            if (state_d == IDLE) begin
                aw_got_q <= 1'b0;
                w_got_q  <= 1'b0;
            end
            // cnt_q counts the wait cycles still to go, including the current one.
            if (state_d == RD_WAIT && state_q != RD_WAIT)      cnt_q <= 4'(RD_LAT - 1);
            else if (state_d == WR_WAIT && state_q != WR_WAIT) cnt_q <= 4'(WR_LAT - 1);
            else if (cnt_q != 4'd0)                            cnt_q <= cnt_q - 4'd1;
            if (rd_enter) begin
                r_data_q <= rd_ok ? mem[rd_idx] : 32'h0;
                r_resp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (wr_enter) b_resp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Memory array: no reset. Only enabled byte lanes are written, on the edge entering WR_RSP.
    always_ff @(posedge clk_i) begin
        if (wr_commit) begin
            for (int b = 0; b < 4; b++)
                if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed testbench for axil_sram_slave.
// Instance 0 uses RD_LAT=WR_LAT=1; instance 1 uses RD_LAT=3, WR_LAT=4.
module tb_axil_sram_slave;
    import axil_sram_pkg::*;

    localparam int RL0 = 1, WL0 = 1, RL1 = 3, WL1 = 4;

    logic        clk, rst_i;
    logic        ar_valid [2], ar_ready [2], r_valid [2], r_ready [2];
    logic        aw_valid [2], aw_ready [2], w_valid [2], w_ready [2];
    logic        b_valid [2], b_ready [2];
    logic [31:0] ar_addr [2], aw_addr [2], w_data [2], r_data [2];
    logic [3:0]  w_strb [2];
    axi_resp_t   r_resp [2], b_resp [2];

    int n_chk = 0;
    int n_err = 0;

    axil_sram_slave #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000), .RD_LAT(RL0), .WR_LAT(WL0)) u_dut0 (
        .clk_i(clk), .rst_i(rst_i),
        .slv_ar_valid_i(ar_valid[0]), .slv_ar_addr_i(ar_addr[0]), .slv_ar_ready_o(ar_ready[0]),
        .slv_r_valid_o(r_valid[0]), .slv_r_data_o(r_data[0]), .slv_r_resp_o(r_resp[0]),
        .slv_r_ready_i(r_ready[0]),
        .slv_aw_valid_i(aw_valid[0]), .slv_aw_addr_i(aw_addr[0]), .slv_aw_ready_o(aw_ready[0]),
        .slv_w_valid_i(w_valid[0]), .slv_w_data_i(w_data[0]), .slv_w_strb_i(w_strb[0]),
        .slv_w_ready_o(w_ready[0]),
        .slv_b_valid_o(b_valid[0]), .slv_b_resp_o(b_resp[0]), .slv_b_ready_i(b_ready[0])
    );

    axil_sram_slave #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000), .RD_LAT(RL1), .WR_LAT(WL1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i),
        .slv_ar_valid_i(ar_valid[1]), .slv_ar_addr_i(ar_addr[1]), .slv_ar_ready_o(ar_ready[1]),
        .slv_r_valid_o(r_valid[1]), .slv_r_data_o(r_data[1]), .slv_r_resp_o(r_resp[1]),
        .slv_r_ready_i(r_ready[1]),
        .slv_aw_valid_i(aw_valid[1]), .slv_aw_addr_i(aw_addr[1]), .slv_aw_ready_o(aw_ready[1]),
        .slv_w_valid_i(w_valid[1]), .slv_w_data_i(w_data[1]), .slv_w_strb_i(w_strb[1]),
        .slv_w_ready_o(w_ready[1]),
        .slv_b_valid_o(b_valid[1]), .slv_b_resp_o(b_resp[1]), .slv_b_ready_i(b_ready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rl(input int d);
        return (d == 0) ? RL0 : RL1;
    endfunction

    function automatic int wl(input int d);
        return (d == 0) ? WL0 : WL1;
    endfunction

    task automatic do_read(input int d, input logic [31:0] a, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
        int n;
        logic [31:0] d0;
        ar_valid[d] = 1'b1;
        ar_addr[d]  = a;
        #1;
        check("ar_ready", 32'(ar_ready[d]), 1);
        tick();
        ar_valid[d] = 1'b0;
        n = 1;
        #1;
        while (!r_valid[d] && n < 64) begin
            tick();
            #1;
            n++;
        end
        check("rd_lat", n, rl(d));
        d0 = r_data[d];
        for (int i = 0; i < hold; i++) begin
            tick();
            #1;
            check("r_hold_valid", 32'(r_valid[d]), 1);
            check("r_hold_data", r_data[d], d0);
        end
        data = r_data[d];
        resp = r_resp[d];
        r_ready[d] = 1'b1;
        tick();
        r_ready[d] = 1'b0;
        #1;
        check("rd_back_idle", 32'(ar_ready[d]), 1);
    endtask

    // gap=0: AW and W arrive together. gap>0: AW arrives gap cycles after W.
    task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] dat,
                            input logic [3:0] s, input int gap, input int hold,
                            output logic [1:0] resp);
        int n;
        w_valid[d] = 1'b1;
        w_data[d]  = dat;
        w_strb[d]  = s;
        if (gap == 0) begin
            aw_valid[d] = 1'b1;
            aw_addr[d]  = a;
        end
        #1;
        check("w_ready", 32'(w_ready[d]), 1);
        tick();
        w_valid[d] = 1'b0;
        if (gap > 0) begin
            for (int i = 1; i < gap; i++) begin
                #1;
                check("collect_aw_ready", 32'(aw_ready[d]), 1);
                check("collect_w_ready", 32'(w_ready[d]), 0);
                check("collect_ar_ready", 32'(ar_ready[d]), 0);
                tick();
            end
            aw_valid[d] = 1'b1;
            aw_addr[d]  = a;
            #1;
            check("late_aw_ready", 32'(aw_ready[d]), 1);
            tick();
        end
        aw_valid[d] = 1'b0;
        n = 1;
        #1;
        while (!b_valid[d] && n < 64) begin
            tick();
            #1;
            n++;
        end
        check("wr_lat", n, wl(d));
        if (hold > 0) begin
            ar_valid[d] = 1'b1;
            ar_addr[d]  = a;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            #1;
            check("b_hold_valid", 32'(b_valid[d]), 1);
            check("b_hold_ar_ready", 32'(ar_ready[d]), 0);
        end
        ar_valid[d] = 1'b0;
        resp = b_resp[d];
        b_ready[d] = 1'b1;
        tick();
        b_ready[d] = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;

    initial begin
        for (int d = 0; d < 2; d++) begin
            ar_valid[d] = 0; ar_addr[d] = 0; r_ready[d] = 0;
            aw_valid[d] = 0; aw_addr[d] = 0; w_valid[d] = 0;
            w_data[d] = 0; w_strb[d] = 0; b_ready[d] = 0;
        end
        rst_i = 1'b1;
        repeat (3) tick();
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_r_valid", 32'(r_valid[d]), 0);
            check("rst_b_valid", 32'(b_valid[d]), 0);
            check("rst_r_data", r_data[d], 0);
            check("rst_r_resp", 32'(r_resp[d]), 0);
            check("rst_b_resp", 32'(b_resp[d]), 0);
            check("rst_ar_ready", 32'(ar_ready[d]), 1);
            check("rst_aw_ready", 32'(aw_ready[d]), 1);
        end
        ar_valid[0] = 1'b1;
        #1;
        check("rst_aw_ready_arv", 32'(aw_ready[0]), 0);
        check("rst_w_ready_arv", 32'(w_ready[0]), 0);
        ar_valid[0] = 1'b0;
        tick();
        rst_i = 1'b0;
        #1;
        check("post_rst_ar_ready", 32'(ar_ready[0]), 1);
        check("post_rst_r_valid", 32'(r_valid[0]), 0);

        // basic write/read, latency 1
        do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, rs);
        check("wr1_resp", 32'(rs), 0);
        do_read(0, 32'h8000_0010, 0, rd, rs);
        check("rd1_data", rd, 32'hDEAD_BEEF);
        check("rd1_resp", 32'(rs), 0);

        // byte strobes
        do_write(0, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, 0, rs);
        do_read(0, 32'h8000_0010, 0, rd, rs);
        check("strb_data", rd, 32'hDE22_BE44);

        // first and last word of the window
        do_write(0, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, 0, rs);
        do_write(0, 32'h8000_0FFC, 32'h5A5A_5A5A, 4'hF, 0, 0, rs);
        check("last_wr_resp", 32'(rs), 0);
        do_read(0, 32'h8000_0FFC, 0, rd, rs);
        check("last_rd_data", rd, 32'h5A5A_5A5A);

        // read priority over a write presented in the same cycle
        ar_valid[0] = 1'b1; ar_addr[0] = 32'h8000_0000;
        aw_valid[0] = 1'b1; aw_addr[0] = 32'h8000_0000;
        w_valid[0]  = 1'b1; w_data[0]  = 32'hCAFE_0001; w_strb[0] = 4'hF;
        #1;
        check("prio_ar_ready", 32'(ar_ready[0]), 1);
        check("prio_aw_ready", 32'(aw_ready[0]), 0);
        check("prio_w_ready", 32'(w_ready[0]), 0);
        tick();
        ar_valid[0] = 1'b0;
        #1;
        check("prio_r_valid", 32'(r_valid[0]), 1);
        check("prio_r_data", r_data[0], 32'h0BAD_F00D);
        check("prio_aw_blocked", 32'(aw_ready[0]), 0);
        r_ready[0] = 1'b1;
        tick();
        r_ready[0] = 1'b0;
        #1;
        check("prio_aw_ready_idle", 32'(aw_ready[0]), 1);
        check("prio_w_ready_idle", 32'(w_ready[0]), 1);
        tick();
        aw_valid[0] = 1'b0;
        w_valid[0]  = 1'b0;
        #1;
        check("prio_b_valid", 32'(b_valid[0]), 1);
        check("prio_b_resp", 32'(b_resp[0]), 0);
        b_ready[0] = 1'b1;
        tick();
        b_ready[0] = 1'b0;
        do_read(0, 32'h8000_0000, 0, rd, rs);
        check("prio_new_data", rd, 32'hCAFE_0001);

        // error decode
        do_read(0, 32'h7FFF_FFFC, 0, rd, rs);
        check("err_lo_resp", 32'(rs), 2);
        check("err_lo_data", rd, 0);
        do_read(0, 32'h8000_1000, 0, rd, rs);
        check("err_hi_resp", 32'(rs), 2);
        check("err_hi_data", rd, 0);
        do_write(0, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 0, rs);
        check("err_wr_hi_resp", 32'(rs), 2);
        do_write(0, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0, 0, rs);
        check("err_wr_lo_resp", 32'(rs), 2);
        do_read(0, 32'h8000_0000, 0, rd, rs);
        check("err_keep_w0", rd, 32'hCAFE_0001);
        do_read(0, 32'h8000_0010, 0, rd, rs);
        check("err_keep_w4", rd, 32'hDE22_BE44);
        do_read(0, 32'h8000_0FFC, 0, rd, rs);
        check("err_keep_w1023", rd, 32'h5A5A_5A5A);

        // longer latencies: W then AW four cycles later, b_ready held low
        do_write(1, 32'h8000_0020, 32'h1234_5678, 4'hF, 4, 4, rs);
        check("skew_resp", 32'(rs), 0);
        do_read(1, 32'h8000_0020, 3, rd, rs);
        check("skew_rd_data", rd, 32'h1234_5678);
        check("skew_rd_resp", 32'(rs), 0);

        // reset two cycles after AW+W capture: the write must never land
        aw_valid[1] = 1'b1; aw_addr[1] = 32'h8000_0020;
        w_valid[1]  = 1'b1; w_data[1]  = 32'hFFFF_0000; w_strb[1] = 4'hF;
        tick();
        aw_valid[1] = 1'b0;
        w_valid[1]  = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        check("mid_rst_b_valid", 32'(b_valid[1]), 0);
        tick();
        rst_i = 1'b0;
        #1;
        check("mid_rst_ar_ready", 32'(ar_ready[1]), 1);
        check("mid_rst_aw_ready", 32'(aw_ready[1]), 1);
        check("mid_rst_w_ready", 32'(w_ready[1]), 1);
        check("mid_rst_r_data", r_data[1], 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check("mid_rst_no_b", 32'(b_valid[1]), 0);
        end
        do_read(1, 32'h8000_0020, 0, rd, rs);
        check("mid_rst_mem", rd, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
